vred_operand_fetch: RTL and testbench
=====================================

# vred_operand_fetch

Operand-collection stage that sits directly upstream of the vector reduction unit. It accepts a reduction request (sew, lmul, vs1, vs2, vd register numbers) and reads vs1 plus the 1- or 4-register vs2 group through a single vector-register-file read port, one register per cycle. It assembles the 128-bit `vs1_bus` and 512-bit `vs2_bus` and presents them, with a valid/ready handshake, to the reduction datapath.

## Interface
- `VLEN_BITS`, 128, bits per vector register
- `VREG_AW`, 5, register-number width (32 architectural registers)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request
- `req_sew`  in  1  0: int8, 1: int32; passed through
- `req_lmul`  in  1  0: 1-register vs2, 1: 4-register vs2 group
- `req_vs1`, `req_vs2`, `req_vd`  in  VREG_AW each  register numbers
- `vrf_rd_en`  out  1  read strobe
- `vrf_rd_addr`  out  VREG_AW  read address
- `vrf_rd_data`  in  VLEN_BITS  read data, valid exactly 1 cycle after the strobe
- `out_valid`  out  1  operands assembled
- `out_ready`  in  1  reduction unit accepts
- `out_sew`, `out_lmul`  out  1 each  latched request fields
- `out_vd`  out  VREG_AW  latched destination
- `vs1_bus`  out  VLEN_BITS  vs1 contents
- `vs2_bus`  out  4*VLEN_BITS  vs2 group; register vs2+k in slice [k*VLEN_BITS +: VLEN_BITS]
- `err_misalign`  out  1  one-cycle pulse: request rejected

## Operation
- FSM states: IDLE, FETCH, DRAIN, ISSUE.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch all request fields and clear all bus registers to 0.
  - Misaligned request (`req_lmul`=1 and `req_vs2[1:0]`≠0): the request is consumed, `err_misalign` pulses the next cycle, no reads occur, and the FSM stays in IDLE.
  - Otherwise go to FETCH.
- Read count N = 2 if lmul=0, or 5 if lmul=1.
- Read order: vs1, vs2, vs2+1, vs2+2, vs2+3.
- Addresses never wrap: alignment guarantees vs2+3 ≤ 31.
- FETCH:
  - `vrf_rd_en`=1 every cycle; a 3-bit issue counter goes 0..N-1.
  - Data returned for issue index 0 goes to `vs1_bus`; data for index j≥1 goes to vs2 slice j-1.
  - After the last issue, go to DRAIN.
- DRAIN: capture the final read data, then go to ISSUE.
- ISSUE:
  - `out_valid`=1, with all outputs held stable until `out_ready`.
  - On handshake, go to IDLE.
- When lmul=0, vs2 slices 1–3 read as 0.
- vs1 may equal, or fall inside, the vs2 group; each register is simply read again, with no special handling.
- `req_ready`=0 in every state except IDLE. There is no accept-on-issue bypass.

## Timing
- Reset (async assert, sync-safe deassert) puts the FSM in IDLE, with these values:
  - `req_ready`=1.
  - `out_valid`, `vrf_rd_en`, `err_misalign` = 0.
  - `vrf_rd_addr`, `out_*`, `vs1_bus`, `vs2_bus` = 0.
- Reset mid-fetch or mid-issue abandons the request silently; read data arriving after reset is ignored.
- With the request accepted at edge T:
  - `vrf_rd_en` is high in cycles T+1..T+N.
  - Data is captured at edges T+2..T+N+1.
  - `out_valid` rises in cycle T+N+2. Latency is therefore 4 cycles for lmul=0 and 7 for lmul=1.
- `err_misalign` is high for exactly the cycle after a rejected handshake.
- Earliest next accept: the cycle after the `out_valid`/`out_ready` handshake.
- `out_ready` held high before `out_valid` rises: the handshake completes in the first ISSUE cycle.
- `req_valid` while busy: ignored; `req_ready`=0.

## Structure
- Shared vector package holds:
  - the FSM state enum;
  - `SEW_INT8`/`SEW_INT32` and `LMUL_1`/`LMUL_4` encodings;
  - `VLEN_BITS` and `VREG_AW` defaults, shared with the reduction unit.
- One sub-module, `vred_operand_buf`: the slice-addressed capture register file for vs1 and vs2 (write index, write enable, clear).
- FSM and counter stay in the top module.

## Test plan
- Reset, then check idle levels: `req_ready`=1; `out_valid`=0; `vs2_bus`=0.
- lmul=0, sew=0, vs1=3, vs2=8, vd=1, VRF[r] = {16{r[7:0]}}:
  - reads go to addresses 3 then 8;
  - `out_valid` arrives 4 cycles after accept;
  - `vs1_bus`=VRF[3], slice0=VRF[8], slices 1–3 = 0.
- lmul=1, sew=1, vs1=0, vs2=12:
  - reads go to addresses 0, 12, 13, 14, 15 on consecutive cycles;
  - `out_valid` arrives 7 cycles after accept;
  - slice k = VRF[12+k].
- Misaligned request (lmul=1, vs2=13): `err_misalign` pulses one cycle, `vrf_rd_en` never asserts, and `req_ready` stays 1.
- Backpressure: hold `out_ready`=0 for 5 cycles while `req_valid` is high. Outputs must stay stable and `req_ready` stays 0; release `out_ready`, and the next request is accepted the following cycle.
- Assert `rst_n` low during the third FETCH cycle: all outputs return to 0 immediately. A new request then completes correctly.

Source files
------------

// File: rtl/vred_operand_fetch_pkg.sv
// Shared vector-reduction definitions: FSM states, field encodings
// and register-file geometry defaults used by the operand stage.
package vred_operand_fetch_pkg;

    localparam int DEF_VLEN_BITS = 128;
    localparam int DEF_VREG_AW   = 5;

    localparam logic SEW_INT8  = 1'b0;
    localparam logic SEW_INT32 = 1'b1;
    localparam logic LMUL_1    = 1'b0;
    localparam logic LMUL_4    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_ISSUE
    } vred_state_t;

    // Index of the final read: vs1 plus one or four vs2 registers.
    function automatic logic [2:0] last_idx(input logic lmul);
        return (lmul == LMUL_4) ? 3'd4 : 3'd1;
    endfunction

    function automatic logic misaligned(input logic lmul,
                                        input logic [1:0] vs2_lo);
        return (lmul == LMUL_4) && (vs2_lo != 2'd0);
    endfunction

endpackage

// File: rtl/vred_operand_buf.sv
// Capture registers for vs1 and the vs2 group; index 0 writes vs1,
// index j>=1 writes vs2 slice j-1.
module vred_operand_buf
    import vred_operand_fetch_pkg::*;
#(
    parameter int VLEN_BITS = DEF_VLEN_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_we,
    input  logic [2:0]             i_idx,
    input  logic [VLEN_BITS-1:0]   i_data,
    output logic [VLEN_BITS-1:0]   o_vs1,
    output logic [4*VLEN_BITS-1:0] o_vs2
);

    logic [VLEN_BITS-1:0]      r_vs1;
    logic [3:0][VLEN_BITS-1:0] r_vs2;
    logic [1:0]                w_slot;

    assign w_slot = 2'(i_idx - 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs1 <= '0;
            r_vs2 <= '0;
        end else if (i_clr) begin
            r_vs1 <= '0;
            r_vs2 <= '0;
        end else if (i_we) begin
            if (i_idx == 3'd0) begin
                r_vs1 <= i_data;
            end else begin
                r_vs2[w_slot] <= i_data;
            end
        end
    end

    assign o_vs1 = r_vs1;
    assign o_vs2 = r_vs2;

endmodule

// File: rtl/vred_operand_fetch.sv
// Operand fetch for the reduction unit: reads vs1 and the vs2 group
// through one VRF port and presents them with a valid/ready handshake.
module vred_operand_fetch
    import vred_operand_fetch_pkg::*;
#(
    parameter int VLEN_BITS = DEF_VLEN_BITS,
    parameter int VREG_AW   = DEF_VREG_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_sew,
    input  logic                   req_lmul,
    input  logic [VREG_AW-1:0]     req_vs1,
    input  logic [VREG_AW-1:0]     req_vs2,
    input  logic [VREG_AW-1:0]     req_vd,
    output logic                   vrf_rd_en,
    output logic [VREG_AW-1:0]     vrf_rd_addr,
    input  logic [VLEN_BITS-1:0]   vrf_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sew,
    output logic                   out_lmul,
    output logic [VREG_AW-1:0]     out_vd,
    output logic [VLEN_BITS-1:0]   vs1_bus,
    output logic [4*VLEN_BITS-1:0] vs2_bus,
    output logic                   err_misalign
);

    vred_state_t        r_state;
    logic               r_req_ready;
    logic               r_rd_en;
    logic [VREG_AW-1:0] r_rd_addr;
    logic [2:0]         r_cnt;
    logic               r_cap_vld;
    logic [2:0]         r_cap_idx;
    logic               r_out_valid;
    logic               r_err;
    logic               r_sew;
    logic               r_lmul;
    logic [VREG_AW-1:0] r_vd;
    logic [VREG_AW-1:0] r_vs1;
    logic [VREG_AW-1:0] r_vs2;
    logic               w_accept;

    assign w_accept = req_valid && r_req_ready && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_cnt       <= '0;
            r_cap_vld   <= 1'b0;
            r_cap_idx   <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_sew       <= 1'b0;
            r_lmul      <= 1'b0;
            r_vd        <= '0;
            r_vs1       <= '0;
            r_vs2       <= '0;
        end else begin
            r_err     <= 1'b0;
            // Read data lands one cycle after its strobe.
            r_cap_vld <= r_rd_en;
            r_cap_idx <= r_cnt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sew  <= req_sew;
                        r_lmul <= req_lmul;
                        r_vd   <= req_vd;
                        r_vs1  <= req_vs1;
                        r_vs2  <= req_vs2;
                        if (misaligned(req_lmul, req_vs2[1:0])) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state     <= ST_FETCH;
                            r_req_ready <= 1'b0;
                            r_rd_en     <= 1'b1;
                            r_rd_addr   <= req_vs1;
                            r_cnt       <= 3'd0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (r_cnt == last_idx(r_lmul)) begin
                        r_rd_en <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        // Next index is r_cnt+1, i.e. register vs2+r_cnt.
                        r_cnt     <= r_cnt + 3'd1;
                        r_rd_addr <= r_vs2 + VREG_AW'(r_cnt);
                    end
                end
                ST_DRAIN: begin
                    r_state     <= ST_ISSUE;
                    r_out_valid <= 1'b1;
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    vred_operand_buf #(
        .VLEN_BITS (VLEN_BITS)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_accept),
        .i_we   (r_cap_vld),
        .i_idx  (r_cap_idx),
        .i_data (vrf_rd_data),
        .o_vs1  (vs1_bus),
        .o_vs2  (vs2_bus)
    );

    assign req_ready    = r_req_ready;
    assign vrf_rd_en    = r_rd_en;
    assign vrf_rd_addr  = r_rd_addr;
    assign out_valid    = r_out_valid;
    assign out_sew      = r_sew;
    assign out_lmul     = r_lmul;
    assign out_vd       = r_vd;
    assign err_misalign = r_err;

endmodule

// File: tb/tb_vred_operand_fetch.sv
// Directed bench for vred_operand_fetch with a one-cycle-latency
// VRF model holding {16{r}} in register r.
module tb_vred_operand_fetch;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_sew;
    logic         req_lmul;
    logic [4:0]   req_vs1;
    logic [4:0]   req_vs2;
    logic [4:0]   req_vd;
    logic         vrf_rd_en;
    logic [4:0]   vrf_rd_addr;
    logic [127:0] vrf_rd_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sew;
    logic         out_lmul;
    logic [4:0]   out_vd;
    logic [127:0] vs1_bus;
    logic [511:0] vs2_bus;
    logic         err_misalign;

    int n_asrt = 0;
    int n_fail = 0;
    int lat;
    int rd_q[$];

    always #5 clk = ~clk;

    vred_operand_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sew      (req_sew),
        .req_lmul     (req_lmul),
        .req_vs1      (req_vs1),
        .req_vs2      (req_vs2),
        .req_vd       (req_vd),
        .vrf_rd_en    (vrf_rd_en),
        .vrf_rd_addr  (vrf_rd_addr),
        .vrf_rd_data  (vrf_rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sew      (out_sew),
        .out_lmul     (out_lmul),
        .out_vd       (out_vd),
        .vs1_bus      (vs1_bus),
        .vs2_bus      (vs2_bus),
        .err_misalign (err_misalign)
    );

    function automatic logic [127:0] vrf(input int r);
        logic [7:0] b;
        b = 8'(r);
        return {16{b}};
    endfunction

    always @(posedge clk) begin
        vrf_rd_data <= vrf_rd_en ? vrf(int'(vrf_rd_addr)) : {128{1'b1}};
        if (rst_n && vrf_rd_en) rd_q.push_back(int'(vrf_rd_addr));
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sew, input logic lmul, input int vs1,
                        input int vs2, input int vd);
        req_valid = 1'b1;
        req_sew   = sew;
        req_lmul  = lmul;
        req_vs1   = 5'(vs1);
        req_vs2   = 5'(vs2);
        req_vd    = 5'(vd);
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 40) begin
            step();
            l++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_sew   = 1'b0;
        req_lmul  = 1'b0;
        req_vs1   = '0;
        req_vs2   = '0;
        req_vd    = '0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_req_ready", 512'(req_ready), 512'd1);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_vs2_bus", vs2_bus, 512'd0);
        chk("rst_rd_en", 512'(vrf_rd_en), 512'd0);

        // lmul=1 register, sew=int8
        rd_q.delete();
        send(1'b0, 1'b0, 3, 8, 1);
        step();
        req_valid = 1'b0;
        chk("t1_rd_en_first", 512'(vrf_rd_en), 512'd1);
        chk("t1_busy_ready", 512'(req_ready), 512'd0);
        wait_valid(lat);
        chk("t1_latency", 512'(lat), 512'd4);
        chk("t1_nreads", 512'(rd_q.size()), 512'd2);
        if (rd_q.size() == 2) begin
            chk("t1_addr0", 512'(rd_q[0]), 512'd3);
            chk("t1_addr1", 512'(rd_q[1]), 512'd8);
        end
        chk("t1_vs1", 512'(vs1_bus), 512'(vrf(3)));
        chk("t1_vs2", vs2_bus, {384'd0, vrf(8)});
        chk("t1_vd", 512'(out_vd), 512'd1);
        chk("t1_lmul", 512'(out_lmul), 512'd0);
        out_ready = 1'b1;
        step();
        chk("t1_done_valid", 512'(out_valid), 512'd0);
        chk("t1_done_ready", 512'(req_ready), 512'd1);

        // 4-register group, out_ready already high
        rd_q.delete();
        send(1'b1, 1'b1, 0, 12, 2);
        step();
        req_valid = 1'b0;
        wait_valid(lat);
        chk("t2_latency", 512'(lat), 512'd7);
        chk("t2_nreads", 512'(rd_q.size()), 512'd5);
        if (rd_q.size() == 5) begin
            chk("t2_addr0", 512'(rd_q[0]), 512'd0);
            for (int k = 1; k < 5; k++)
                chk($sformatf("t2_addr%0d", k), 512'(rd_q[k]), 512'(11 + k));
        end
        chk("t2_vs1", 512'(vs1_bus), 512'(vrf(0)));
        chk("t2_vs2", vs2_bus, {vrf(15), vrf(14), vrf(13), vrf(12)});
        chk("t2_sew", 512'(out_sew), 512'd1);
        step();
        chk("t2_first_issue_hs", 512'(out_valid), 512'd0);
        out_ready = 1'b0;

        // misaligned group
        rd_q.delete();
        send(1'b0, 1'b1, 4, 13, 5);
        step();
        req_valid = 1'b0;
        chk("mis_err_pulse", 512'(err_misalign), 512'd1);
        chk("mis_ready", 512'(req_ready), 512'd1);
        chk("mis_rd_en", 512'(vrf_rd_en), 512'd0);
        chk("mis_bus_clr", vs2_bus, 512'd0);
        step();
        chk("mis_err_low", 512'(err_misalign), 512'd0);
        step();
        step();
        chk("mis_no_reads", 512'(rd_q.size()), 512'd0);
        chk("mis_ready2", 512'(req_ready), 512'd1);

        // backpressure with a request waiting
        send(1'b0, 1'b0, 5, 4, 7);
        step();
        wait_valid(lat);
        chk("bp_latency", 512'(lat), 512'd4);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_valid", 512'(out_valid), 512'd1);
            chk("bp_ready", 512'(req_ready), 512'd0);
            chk("bp_vs1", 512'(vs1_bus), 512'(vrf(5)));
            chk("bp_vs2", vs2_bus, {384'd0, vrf(4)});
            chk("bp_vd", 512'(out_vd), 512'd7);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_ready", 512'(req_ready), 512'd1);
        send(1'b0, 1'b0, 9, 10, 3);
        out_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("bp_next_accept", 512'(req_ready), 512'd0);
        chk("bp_next_addr", 512'(vrf_rd_addr), 512'd9);
        wait_valid(lat);
        chk("bp_next_vs2", vs2_bus, {384'd0, vrf(10)});
        chk("bp_next_vs1", 512'(vs1_bus), 512'(vrf(9)));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // reset during the third fetch cycle
        send(1'b1, 1'b1, 1, 20, 6);
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("rf_pre_vs1", 512'(vs1_bus), 512'(vrf(1)));
        #2 rst_n = 1'b0;
        #1;
        chk("rf_rd_en", 512'(vrf_rd_en), 512'd0);
        chk("rf_addr", 512'(vrf_rd_addr), 512'd0);
        chk("rf_vs1", 512'(vs1_bus), 512'd0);
        chk("rf_vs2", vs2_bus, 512'd0);
        chk("rf_vd", 512'(out_vd), 512'd0);
        chk("rf_ready", 512'(req_ready), 512'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("rf_ignored_data", vs2_bus, 512'd0);
        send(1'b0, 1'b1, 31, 28, 9);
        step();
        req_valid = 1'b0;
        wait_valid(lat);
        chk("rf_new_latency", 512'(lat), 512'd7);
        chk("rf_new_vs1", 512'(vs1_bus), 512'(vrf(31)));
        chk("rf_new_vs2", vs2_bus, {vrf(31), vrf(30), vrf(29), vrf(28)});
        chk("rf_new_vd", 512'(out_vd), 512'd9);
        out_ready = 1'b1;
        step();
        chk("rf_new_done", 512'(out_valid), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
